alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execution-side consumer of the 3-bit alucontrol code produced by the ALU decoder.
//   Accepts one operation per valid/ready handshake and computes the result.
//   Returns the registered result, zero flag and illegal flag on a second valid/ready handshake.
//   ADD/SUB/AND/OR/SLT complete in one cycle. Code 3'b011 (MUL, low word) runs as an iterative
//   shift-add sequence so the multi-cycle datapath can stall on it.
// PARAMETERS
//   WIDTH    32   operand/result width in bits; must be >= 2
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   in_valid    in   1      operation request valid
//   in_ready    out  1      unit can accept a request this cycle
//   alucontrol  in   3      010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul; 100/101 illegal
//   srca        in   WIDTH  operand A
//   srcb        in   WIDTH  operand B
//   out_valid   out  1      result/zero/illegal valid
//   out_ready   in   1      consumer takes the result this cycle
//   result      out  WIDTH  registered result
//   zero        out  1      result == 0 (registered with result)
//   illegal     out  1      accepted code was 100 or 101
// BEHAVIOUR
//   Reset (reset==0, async):
//   - state=IDLE; out_valid=0, result=0, zero=0, illegal=0; mul counter=0.
//   - in_ready=0 while reset is low.
//   Handshakes:
//   - Request is accepted on the clk edge where in_valid && in_ready.
//   - Result is consumed on the edge where out_valid && out_ready.
//   - in_ready = (state==IDLE) && (!out_valid || out_ready). A consume and a new accept may
//     occur in the same cycle, giving 1 op/cycle throughput for single-cycle ops.
//   - While out_valid && !out_ready: result/zero/illegal are held stable; no new accept.
//   - Inputs are ignored when not accepted.
//   States: IDLE, MUL.
//   - IDLE, accept single-cycle or illegal code: load output regs; out_valid=1 next cycle
//     (latency 1). State stays IDLE.
//   - IDLE, accept 011: latch srca/srcb; acc=0; cnt=0; go to MUL.
//   - MUL: each cycle, if multiplier LSB is set then acc += multiplicand; multiplicand <<= 1;
//     multiplier >>= 1; cnt++.
//   - MUL, cnt==WIDTH-1: write the final acc to result; out_valid=1 next cycle; go to IDLE.
//     MUL latency is WIDTH cycles from accept to out_valid (32 at default).
//   Arithmetic (all mod 2^WIDTH, no overflow flag):
//   - add = a+b; sub = a-b (two's complement); and/or bitwise.
//   - slt = {0..,1} if $signed(a) < $signed(b), else 0.
//   - mul = low WIDTH bits of the unsigned product.
//   - Illegal codes 100/101: result=0, zero=1, illegal=1; accepted like a normal 1-cycle op.
//   - illegal is 0 for all legal codes. zero is computed from the value loaded into result.
//   Boundaries:
//   - 0x7FFFFFFF+1 wraps to 0x80000000. slt(0x80000000, 0x7FFFFFFF)=1.
//   - MUL by 0 still takes the full WIDTH cycles; there is no early exit.
//   - Reset low mid-MUL aborts: registers clear immediately; IDLE after reset is released.
// STRUCTURE
//   - alu_pkg: localparams ALU_ADD/SUB/AND/OR/SLT/MUL (3-bit codes as above); typedef enum
//     logic {IDLE, MUL} alu_state_t. This package is shared with the ALU decoder.
//   - Sub-module alu_mul_iter: shift-add engine with ports start, a, b, busy, done, product.
//     Owns cnt, acc and the shift registers. Top level holds the FSM, handshake and output regs.
// TESTING
//   - add 5,7, out_ready=1 -> out_valid 1 cycle after accept; result=12, zero=0, illegal=0.
//   - sub 3,3 -> result=0, zero=1. slt 0xFFFFFFFF,1 -> result=1. or 0xF0,0x0F -> 0xFF.
//   - Back-to-back add ops, out_ready=1 every cycle -> one accept and one result per cycle.
//   - mul 6,7 -> in_ready=0 for the MUL cycles; result=42 with out_valid 32 cycles after accept.
//     mul 0xFFFFFFFF,2 -> 0xFFFFFFFE.
//   - out_ready=0 for 5 cycles after an add result -> result held, in_ready=0, pending in_valid
//     not accepted until the consume cycle.
//   - Code 100 -> illegal=1, result=0, zero=1. Reset pulsed at MUL cycle 10 -> out_valid=0
//     immediately, no result emitted, next add works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: alucontrol codes and execution-unit state type shared with the ALU decoder
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_MUL = 3'b011;
  typedef enum logic {IDLE, MUL} alu_state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier producing the low WIDTH bits in WIDTH cycles
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  // the last step's partial product is folded in combinationally so the result is ready on the final cycle
  assign done    = busy && cnt == CW'(WIDTH - 1);
  assign product = acc + (mplier[0] ? mcand : '0);
  // load operands on start, then one shift-add step per cycle with no early exit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      busy   <= !done;
      cnt    <= cnt + 1'b1;
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU executing alucontrol codes, single-cycle ops plus iterative MUL
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  alu_state_t       state;
  logic             accept, is_illegal, mul_busy, mul_done;
  logic [WIDTH-1:0] alu_res, mul_product;
  assign in_ready   = reset && state == IDLE && !mul_busy && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign is_illegal = alucontrol[2:1] == 2'b10;
  // single-cycle result; illegal codes yield zero
  always_comb
    alu_res = alucontrol == ALU_ADD ? srca + srcb :
              alucontrol == ALU_SUB ? srca - srcb :
              alucontrol == ALU_AND ? srca & srcb :
              alucontrol == ALU_OR  ? srca | srcb :
              alucontrol == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)} :
              '0;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && alucontrol == ALU_MUL),
    .a       (srca),
    .b       (srcb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
  // FSM and output registers; a consume and a new load may share one edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (alucontrol == ALU_MUL) state <= MUL;
        else begin
          out_valid <= 1'b1;
          result    <= alu_res;
          zero      <= alu_res == '0;
          illegal   <= is_illegal;
        end
      end else if (state == MUL && mul_done) begin
        state     <= IDLE;
        out_valid <= 1'b1;
        result    <= mul_product;
        zero      <= mul_product == '0;
        illegal   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  alucontrol = 3'b010;
  logic [31:0] srca = '0, srcb = '0, result;
  logic        in_ready, out_valid, zero, illegal;
  int          errors = 0, checks = 0, n;
  logic        seen;
  alu_exec_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alucontrol = op; srca = a; srcb = b; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z, input logic il);
    issue(tag, op, a, b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, 32'(zero), 32'(z));
    check({tag, "_illegal"}, 32'(illegal), 32'(il));
    tick();
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask
  task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    issue(tag, 3'b011, a, b);
    n = 0; seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) seen = 1'b1;
      tick();
      n++;
    end
    check({tag, "_in_ready_low"}, 32'(seen), 32'd0);
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, 32'(zero), 32'(r == 0));
    tick();
  endtask
  initial begin
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    single("add", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    single("sub", 3'b110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
    single("slt_neg", 3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    single("slt_min", 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
    single("slt_false", 3'b111, 32'd9, 32'd2, 32'd0, 1'b1, 1'b0);
    single("or", 3'b001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
    single("and", 3'b000, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
    single("add_wrap", 3'b010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
    single("ill100", 3'b100, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1);
    single("ill101", 3'b101, 32'd5, 32'd6, 32'd0, 1'b1, 1'b1);
    alucontrol = 3'b010; srca = 32'd1; srcb = 32'd1; in_valid = 1'b1;
    tick();
    check("b2b_1_result", result, 32'd2);
    check("b2b_1_in_ready", 32'(in_ready), 32'd1);
    srca = 32'd2; srcb = 32'd2;
    tick();
    check("b2b_2_valid", 32'(out_valid), 32'd1);
    check("b2b_2_result", result, 32'd4);
    srca = 32'd3; srcb = 32'd4;
    tick();
    check("b2b_3_result", result, 32'd7);
    in_valid = 1'b0;
    tick();
    check("b2b_drain", 32'(out_valid), 32'd0);
    mul("mul_6_7", 32'd6, 32'd7, 32'd42);
    mul("mul_ff_2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    mul("mul_0", 32'd0, 32'd5, 32'd0);
    mul("mul_big", 32'h12345678, 32'h00010001, 32'h68AC5678);
    out_ready = 1'b0;
    issue("hold_add", 3'b010, 32'd10, 32'd20);
    alucontrol = 3'b010; srca = 32'd1; srcb = 32'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'd30);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("hold_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("hold_next_valid", 32'(out_valid), 32'd1);
    check("hold_next_result", result, 32'd3);
    tick();
    issue("rst_mul", 3'b011, 32'd6, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_result", result, 32'd0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_result", 32'(seen), 32'd0);
    single("post_abort_add", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
